// File: rtl/countdown_pkg.sv
`default_nettype none
// ============================================================================
// Module      : countdown_pkg
// Description : Shared types and constants for the H:M:S countdown timer:
//               FSM state encoding, field ranges, field width and the
//               load-value saturation helper.
// Revision    : 1.0 - initial release
// ============================================================================
package countdown_pkg;

    localparam int c_FIELD_W = 8;
    localparam int c_SEC_MAX = 59;
    localparam int c_MIN_MAX = 59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    // Clamp a preset value to the top of its field range
    function automatic logic [c_FIELD_W-1:0] f_sat(input logic [c_FIELD_W-1:0] val,
                                                  input logic [c_FIELD_W-1:0] lim);
        return (val > lim) ? lim : val;
    endfunction

endpackage : countdown_pkg
`default_nettype wire

// File: rtl/down_counter_field.sv
`default_nettype none
// ============================================================================
// Module      : down_counter_field
// Description : One cell of the borrow chain. Holds a value in 0..N-1,
//               decrements when borrow_in is high and wraps 0 -> N-1 while
//               raising borrow_out combinationally. load has priority over
//               borrow_in and saturates load_val to N-1.
// Revision    : 1.0 - initial release
// ============================================================================
module down_counter_field
    import countdown_pkg::*;
#(
    parameter int N = 60
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 load,
    input  logic [c_FIELD_W-1:0] load_val,
    input  logic                 borrow_in,
    output logic [c_FIELD_W-1:0] count,
    output logic                 borrow_out
);

    localparam logic [c_FIELD_W-1:0] c_TOP = c_FIELD_W'(N - 1);

    // Borrow ripples out only when this cell is asked to step below zero
    assign borrow_out = borrow_in && (count == '0);

    // Field register: load first, otherwise step down with wrap
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (load) begin
            count <= f_sat(load_val, c_TOP);
        end else if (borrow_in) begin
            count <= (count == '0) ? c_TOP : (count - c_FIELD_W'(1));
        end
    end

endmodule : down_counter_field
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : H:M:S down-counting timer with built-in one-second prescaler,
//               start/pause/load control and expiry flagging. The three time
//               fields form a borrow chain of down_counter_field cells.
//               Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN - on reaching
//               00:00:00 the timer keeps running and the next tick reloads
//               the last loaded start time instead of entering EXPIRED.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int TICK_DIV  = 100_000_000,
    parameter int MAX_HOURS = 24
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 load,
    input  logic [c_FIELD_W-1:0] load_h,
    input  logic [c_FIELD_W-1:0] load_m,
    input  logic [c_FIELD_W-1:0] load_s,
    input  logic                 start,
    input  logic                 pause,
    output logic [c_FIELD_W-1:0] hours,
    output logic [c_FIELD_W-1:0] minutes,
    output logic [c_FIELD_W-1:0] seconds,
    output logic                 running,
    output logic                 done,
    output logic                 expired
);

    localparam int c_PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);

    state_t                 r_state;
    logic [c_PRESC_W-1:0]   r_presc;

    logic                   w_load_acc;
    logic                   w_tick;
    logic                   w_time_zero;
    logic                   w_zero_tick;
    logic                   w_sec_borrow;
    logic                   w_min_borrow;
    logic                   w_hr_borrow;
    logic                   w_fld_load;
    logic [c_FIELD_W-1:0]   w_ld_h;
    logic [c_FIELD_W-1:0]   w_ld_m;
    logic [c_FIELD_W-1:0]   w_ld_s;

    // Presets are only taken while the timer is not counting
    assign w_load_acc  = load && (r_state != ST_RUN);

    // A pause strobe freezes the prescaler in its own cycle as well
    assign w_tick      = (r_state == ST_RUN) && !pause && (r_presc == c_PRESC_LAST);

    assign w_time_zero = (hours == '0) && (minutes == '0) && (seconds == '0);
    assign w_zero_tick = w_tick && (hours == '0) && (minutes == '0)
                         && (seconds == c_FIELD_W'(1));

    // A tick at 00:00:00 would wrap the whole chain (hours borrows out);
    // reload the fields instead so the counter never goes below zero
    assign w_fld_load  = w_load_acc || w_hr_borrow;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [c_FIELD_W-1:0] r_shadow_h;
    logic [c_FIELD_W-1:0] r_shadow_m;
    logic [c_FIELD_W-1:0] r_shadow_s;

    // Remember the saturated start time for automatic reload
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_shadow_h <= '0;
            r_shadow_m <= '0;
            r_shadow_s <= '0;
        end else if (w_load_acc) begin
            r_shadow_h <= f_sat(load_h, c_FIELD_W'(MAX_HOURS - 1));
            r_shadow_m <= f_sat(load_m, c_FIELD_W'(c_MIN_MAX));
            r_shadow_s <= f_sat(load_s, c_FIELD_W'(c_SEC_MAX));
        end
    end

    assign w_ld_h = w_load_acc ? load_h : r_shadow_h;
    assign w_ld_m = w_load_acc ? load_m : r_shadow_m;
    assign w_ld_s = w_load_acc ? load_s : r_shadow_s;
`else
    assign w_ld_h = w_load_acc ? load_h : '0;
    assign w_ld_m = w_load_acc ? load_m : '0;
    assign w_ld_s = w_load_acc ? load_s : '0;
`endif

    down_counter_field #(.N(c_SEC_MAX + 1)) u_sec (
        .clk        (clk),
        .clr_n      (clr_n),
        .load       (w_fld_load),
        .load_val   (w_ld_s),
        .borrow_in  (w_tick),
        .count      (seconds),
        .borrow_out (w_sec_borrow)
    );

    down_counter_field #(.N(c_MIN_MAX + 1)) u_min (
        .clk        (clk),
        .clr_n      (clr_n),
        .load       (w_fld_load),
        .load_val   (w_ld_m),
        .borrow_in  (w_sec_borrow),
        .count      (minutes),
        .borrow_out (w_min_borrow)
    );

    down_counter_field #(.N(MAX_HOURS)) u_hr (
        .clk        (clk),
        .clr_n      (clr_n),
        .load       (w_fld_load),
        .load_val   (w_ld_h),
        .borrow_in  (w_min_borrow),
        .count      (hours),
        .borrow_out (w_hr_borrow)
    );

    // One-second prescaler: advances only while running, cleared by a load
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_presc <= '0;
        end else if (w_load_acc) begin
            r_presc <= '0;
        end else if ((r_state == ST_RUN) && !pause) begin
            r_presc <= (r_presc == c_PRESC_LAST) ? '0 : (r_presc + c_PRESC_W'(1));
        end
    end

    // Control FSM with registered running/expired/done outputs
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
            running <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_PAUSE: begin
                    if (load) begin
                        r_state <= ST_IDLE;
                        running <= 1'b0;
                        expired <= 1'b0;
                    end else if (start && !pause && !w_time_zero) begin
                        r_state <= ST_RUN;
                        running <= 1'b1;
                        expired <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        r_state <= ST_PAUSE;
                        running <= 1'b0;
                    end else if (w_zero_tick) begin
                        done <= 1'b1;
`ifndef COUNTDOWN_AUTO_RELOAD_EN
                        r_state <= ST_EXPIRED;
                        running <= 1'b0;
                        expired <= 1'b1;
`endif
                    end
                end
                ST_EXPIRED: begin
                    if (load) begin
                        r_state <= ST_IDLE;
                        running <= 1'b0;
                        expired <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    running <= 1'b0;
                    expired <= 1'b0;
                end
            endcase
        end
    end

endmodule : countdown_timer
`default_nettype wire
